// File: rtl/lfsr_pkg.sv
// Shared types and the LFSR step function for the round-robin LFSR arbiter.
package lfsr_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    READY  = 1'b1
  } state_e;

  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR register; load wins over step.
module lfsr8_core
  import lfsr_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h01
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  output logic [7:0] state
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = lfsr8_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_arbiter.sv
// Shares one LFSR among N_REQ requesters with round-robin grants, after a
// warm-up period following reset or seed load.
module lfsr_arbiter
  import lfsr_pkg::*;
#(
  parameter int         N_REQ         = 4,
  parameter int         WARMUP_CYCLES = 4,
  parameter logic [7:0] SEED_DEFAULT  = 8'h01,
  parameter bit         FREE_RUN      = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             seed_valid,
  input  logic [7:0]       seed,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [7:0]       rnd_data,
  output logic             ready,
  output logic [15:0]      grant_cnt
);

  localparam int unsigned NR  = N_REQ;
  localparam int unsigned PW  = $clog2(N_REQ);
  localparam int unsigned WCW = (WARMUP_CYCLES < 1) ? 1 : $clog2(WARMUP_CYCLES + 1);
  localparam logic [WCW-1:0] WARM_INIT  = WCW'(WARMUP_CYCLES);
  localparam state_e         STATE_INIT = (WARMUP_CYCLES > 0) ? WARMUP : READY;

  state_e           state_q, state_d;
  logic [WCW-1:0]   warm_cnt_q, warm_cnt_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [15:0]      grant_cnt_q, grant_cnt_d;

  logic [N_REQ-1:0] gnt_d;
  logic [PW-1:0]    pick_idx;
  logic             xfer;
  logic             in_ready;
  logic             lfsr_step;
  logic [7:0]       lfsr_load_val;
  logic [7:0]       lfsr_state;

  // Gated by reset_n so a zero-warm-up instance stays silent while reset is held.
  assign in_ready = reset_n && (state_q == READY);

  always_comb begin
    int unsigned idx;
    gnt_d    = '0;
    pick_idx = '0;
    xfer     = 1'b0;
    idx      = 0;
    if (in_ready && !seed_valid) begin
      for (int unsigned k = 0; k < NR; k++) begin
        idx = (32'(rr_ptr_q) + k) % NR;
        if (!xfer && req[idx]) begin
          xfer       = 1'b1;
          pick_idx   = PW'(idx);
          gnt_d[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;
    if (seed_valid) begin
      warm_cnt_d = WARM_INIT;
      state_d    = STATE_INIT;
    end else if (state_q == WARMUP) begin
      warm_cnt_d = warm_cnt_q - 1'b1;
      if (warm_cnt_q == WCW'(1)) begin
        state_d = READY;
      end
    end else if (xfer) begin
      rr_ptr_d    = (32'(pick_idx) == NR - 1) ? '0 : pick_idx + 1'b1;
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STATE_INIT;
      warm_cnt_q  <= WARM_INIT;
      rr_ptr_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign lfsr_load_val = (seed == 8'h00) ? SEED_DEFAULT : seed;
  assign lfsr_step     = (state_q == WARMUP) || xfer || (FREE_RUN && state_q == READY);

  lfsr8_core #(
    .RESET_VAL (SEED_DEFAULT)
  ) u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (seed_valid),
    .load_val (lfsr_load_val),
    .step     (lfsr_step),
    .state    (lfsr_state)
  );

  assign gnt       = gnt_d;
  assign ready     = in_ready;
  assign rnd_data  = lfsr_state;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Randomized and directed bench for lfsr_arbiter: unit 0 uses 4 warm-up steps,
// unit 1 none; both are compared against a behavioural model every cycle.
module tb_lfsr_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [1:0]     seed_valid;
  logic [7:0]     seed [2];
  logic [N-1:0]   req  [2];
  logic [N-1:0]   gnt  [2];
  logic [7:0]     rnd  [2];
  logic [1:0]     ready;
  logic [15:0]    cnt  [2];

  int checks = 0;
  int errors = 0;

  int m_lfsr [2];
  int m_warm [2];
  int m_ptr  [2];
  int m_cnt  [2];
  bit m_rdy  [2];
  int wup    [2] = '{4, 0};

  always #5 clk = ~clk;

  lfsr_arbiter #(
    .N_REQ         (N),
    .WARMUP_CYCLES (4),
    .SEED_DEFAULT  (8'h01),
    .FREE_RUN      (1'b0)
  ) dut (
    .clk (clk), .reset_n (reset_n), .seed_valid (seed_valid[0]), .seed (seed[0]),
    .req (req[0]), .gnt (gnt[0]), .rnd_data (rnd[0]), .ready (ready[0]), .grant_cnt (cnt[0])
  );

  lfsr_arbiter #(
    .N_REQ         (N),
    .WARMUP_CYCLES (0),
    .SEED_DEFAULT  (8'h01),
    .FREE_RUN      (1'b0)
  ) dut0 (
    .clk (clk), .reset_n (reset_n), .seed_valid (seed_valid[1]), .seed (seed[1]),
    .req (req[1]), .gnt (gnt[1]), .rnd_data (rnd[1]), .ready (ready[1]), .grant_cnt (cnt[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1 computed arithmetically.
  function automatic int lfsr_step(input int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return ((s << 1) & 255) | fb;
  endfunction

  function automatic int exp_gnt(input int u);
    int idx;
    if (!m_rdy[u] || seed_valid[u]) return 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr[u] + k) % N;
      if (req[u][idx]) return 1 << idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_lfsr[u] = 1;
      m_warm[u] = wup[u];
      m_rdy[u]  = (wup[u] == 0);
      m_ptr[u]  = 0;
      m_cnt[u]  = 0;
    end
  endtask

  // Compare all outputs against the model, then advance both through one edge.
  task automatic cycle();
    int n_lfsr [2];
    int n_warm [2];
    int n_ptr  [2];
    int n_cnt  [2];
    bit n_rdy  [2];
    int g;
    #2;
    for (int u = 0; u < 2; u++) begin
      g = exp_gnt(u);
      check($sformatf("gnt[u%0d]", u),   int'(gnt[u]),   g);
      check($sformatf("ready[u%0d]", u), int'(ready[u]), int'(m_rdy[u]));
      check($sformatf("rnd[u%0d]", u),   int'(rnd[u]),   m_lfsr[u]);
      check($sformatf("cnt[u%0d]", u),   int'(cnt[u]),   m_cnt[u]);
      n_lfsr[u] = m_lfsr[u]; n_warm[u] = m_warm[u]; n_ptr[u] = m_ptr[u];
      n_cnt[u]  = m_cnt[u];  n_rdy[u]  = m_rdy[u];
      if (seed_valid[u]) begin
        n_lfsr[u] = (seed[u] == 8'h00) ? 1 : int'(seed[u]);
        n_warm[u] = wup[u];
        n_rdy[u]  = (wup[u] == 0);
      end else if (!m_rdy[u]) begin
        n_lfsr[u] = lfsr_step(m_lfsr[u]);
        if (m_warm[u] == 1) n_rdy[u] = 1'b1;
        n_warm[u] = m_warm[u] - 1;
      end else if (g != 0) begin
        n_lfsr[u] = lfsr_step(m_lfsr[u]);
        n_ptr[u]  = ($clog2(g) + 1) % N;
        n_cnt[u]  = (m_cnt[u] + 1) & 16'hFFFF;
      end
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      m_lfsr[u] = n_lfsr[u]; m_warm[u] = n_warm[u]; m_ptr[u] = n_ptr[u];
      m_cnt[u]  = n_cnt[u];  m_rdy[u]  = n_rdy[u];
    end
  endtask

  initial begin
    int eg [5] = '{1, 2, 4, 8, 1};
    int er [5] = '{'h11, 'h23, 'h47, 'h8E, 'h1C};
    int rr [4] = '{1, 4, 1, 4};

    reset_n = 1'b0;
    seed_valid = '0;
    for (int u = 0; u < 2; u++) begin
      seed[u] = '0;
      req[u]  = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(ready[0]), 0);
    check("rst_ready0", int'(ready[1]), 0);
    check("rst_rnd", int'(rnd[0]), 'h01);
    check("rst_cnt", int'(cnt[0]), 0);
    reset_n = 1'b1;

    // Warm-up: four discarded steps, then hold at 0x11.
    for (int i = 0; i < 4; i++) begin
      #1 check("warm_ready", int'(ready[0]), 0);
      cycle();
    end
    #1 check("warm_rnd", int'(rnd[0]), 'h11);
    check("warm_done", int'(ready[0]), 1);
    repeat (2) cycle();

    // All requesting: rotation with fresh values each grant.
    req[0] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1 check("rot_gnt", int'(gnt[0]), eg[i]);
      check("rot_rnd", int'(rnd[0]), er[i]);
      cycle();
    end
    check("rot_cnt", int'(cnt[0]), 5);

    // Zero seed is replaced by the default and warm-up repeats.
    req[0] = 4'b0010;
    seed_valid[0] = 1'b1;
    seed[0] = 8'h00;
    #1 check("seed_gnt", int'(gnt[0]), 0);
    cycle();
    seed_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("reseed_ready", int'(ready[0]), 0);
      check("reseed_gnt", int'(gnt[0]), 0);
      cycle();
    end
    #1 check("reseed_gnt2", int'(gnt[0]), 2);
    check("reseed_rnd", int'(rnd[0]), 'h11);
    cycle();
    req[0] = '0;

    // Zero warm-up instance: seed usable next cycle.
    seed_valid[1] = 1'b1;
    seed[1] = 8'h80;
    cycle();
    seed_valid[1] = 1'b0;
    #1 check("nw_ready", int'(ready[1]), 1);
    check("nw_rnd", int'(rnd[1]), 'h80);
    req[1] = 4'b0001;
    cycle();
    req[1] = '0;
    #1 check("nw_step", int'(rnd[1]), 'h01);

    // Round-robin pairs from pointer 0, then a sole requester.
    req[0] = 4'b1000;
    cycle();
    req[0] = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1 check("rr_gnt", int'(gnt[0]), rr[i]);
      cycle();
    end
    req[0] = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1 check("sole_gnt", int'(gnt[0]), 4);
      cycle();
    end

    // Asynchronous reset between edges during a grant stream.
    req[0] = 4'b1111;
    req[1] = 4'b1111;
    repeat (3) cycle();
    #2 reset_n = 1'b0;
    #1;
    check("arst_gnt", int'(gnt[0]), 0);
    check("arst_gnt0", int'(gnt[1]), 0);
    check("arst_ready", int'(ready[0]), 0);
    check("arst_rnd", int'(rnd[0]), 'h01);
    check("arst_cnt", int'(cnt[0]), 0);
    check("arst_cnt0", int'(cnt[1]), 0);
    model_reset();
    req[0] = '0;
    req[1] = '0;
    @(posedge clk);
    #1 check("arst_hold", int'(ready[1]), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("rewarm_ready", int'(ready[0]), 0);
      cycle();
    end
    #1 check("rewarm_rnd", int'(rnd[0]), 'h11);

    // Random traffic, seed loads and zero seeds on both instances.
    for (int i = 0; i < 600; i++) begin
      for (int u = 0; u < 2; u++) begin
        req[u]        = N'($urandom_range(0, 15));
        seed_valid[u] = ($urandom_range(0, 15) == 0);
        seed[u]       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_arbiter.md
Name: lfsr_arbiter

Overview:
- Owns one 8-bit Fibonacci LFSR and shares its output among N_REQ requesters using round-robin grants.
- Sequences the generator: reset and seed loading, a warm-up period of discarded steps, then one step per delivered value.
- Sits between the random-number datapath and its consumers, for example test stimulus generators or game logic. Consumers never drive the LFSR directly.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- WARMUP_CYCLES, 4: LFSR steps discarded after reset or seed load (0 = none).
- SEED_DEFAULT, 8'h01: seed loaded at reset; also substituted for an all-zero seed (must be nonzero).
- FREE_RUN, 0: 1 = LFSR steps every READY cycle even without a grant.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- seed_valid  in  1  load seed this cycle.
- seed  in  8  new seed value.
- req  in  N_REQ  per-requester request; held until granted.
- gnt  out  N_REQ  one-hot grant, combinational from state and req.
- rnd_data  out  8  current LFSR state; valid to the granted requester.
- ready  out  1  high when state is READY.
- grant_cnt  out  16  total completed grants; wraps at 16'hFFFF to 0.

Behaviour:
- LFSR step rule: next = {s[6:0], s[7]^s[5]^s[4]^s[3]} (x^8+x^6+x^5+x^4+1, period 255). From 0x01 the sequence is 01,02,04,08,11,23,47,8E,1C,38.
- Reset (reset_n low, takes effect immediately, no clock needed):
  - lfsr = SEED_DEFAULT, warm_cnt = WARMUP_CYCLES, rr_ptr = 0, grant_cnt = 0.
  - state = WARMUP if WARMUP_CYCLES > 0, else READY.
  - While reset is held: gnt = 0, ready = 0, rnd_data = SEED_DEFAULT.
- States are WARMUP and READY.
- WARMUP:
  - Each cycle: lfsr steps and warm_cnt decrements.
  - On the edge where warm_cnt == 1, go to READY.
  - gnt = 0 and ready = 0 regardless of req.
- READY:
  - ready = 1 and rnd_data = lfsr.
  - If seed_valid = 0 and any req bit is set: gnt is one-hot on the first set req bit searching from rr_ptr upward, wrapping modulo N_REQ.
- Transfer happens on the edge where gnt[i] & req[i]. On that edge:
  - lfsr steps;
  - rr_ptr = (i+1) mod N_REQ;
  - grant_cnt increments.
- Zero-latency handshake: the requester captures rnd_data in the same cycle gnt is high.
- READY with no grant: lfsr holds, or steps if FREE_RUN = 1. rr_ptr holds.
- Seed load: when seed_valid = 1 in any state, on the next edge:
  - lfsr = (seed == 0) ? SEED_DEFAULT : seed;
  - warm_cnt = WARMUP_CYCLES;
  - state = WARMUP, or READY if WARMUP_CYCLES = 0;
  - rr_ptr and grant_cnt are unchanged.
- Seed load has priority: gnt = 0 in any cycle with seed_valid = 1, even in READY.
- The all-zero lockup state is unreachable: zero seeds are replaced, and the SEED_DEFAULT = 0 parameter value is illegal.
- At most one grant per cycle. A requester may hold req across consecutive grants and is re-granted only when it is the sole requester.
- A req that drops before being granted is simply not served. No state is kept per requester.

Decomposition:
- Package lfsr_pkg holds:
  - state enum {WARMUP, READY};
  - LFSR_TAPS constant 8'b1011_1000 (bits 7,5,4,3);
  - function lfsr8_next(s).
- Sub-module lfsr8_core (8-bit register with load, load_val and step inputs) is natural. The arbiter instantiates it and keeps the FSM, counters and round-robin pick.

Test Plan:
- Reset, req = 0: ready = 0 for 4 cycles; then ready = 1 and rnd_data = 0x11, holding at 0x11 with FREE_RUN = 0; gnt = 0.
- After warm-up, req = 4'b1111 held: gnt = 0001, 0010, 0100, 1000, 0001 on consecutive cycles with rnd_data = 11, 23, 47, 8E, 1C; grant_cnt = 5.
- In READY, seed_valid = 1 with seed = 0x00 and req = 4'b0010:
  - gnt = 0 in the seed cycle;
  - then 4 cycles with ready = 0 and gnt = 0;
  - then gnt = 0010 with rnd_data = 0x11.
- WARMUP_CYCLES = 0 instance: seed = 0x80 → next cycle ready = 1, rnd_data = 0x80; one grant → rnd_data = 0x01.
- Round-robin with req = 4'b0101 from rr_ptr = 0: grants 0, 2, 0, 2. Single req = 4'b0100: gnt = 0100 on every cycle.
- reset_n pulled low asynchronously mid-grant stream (between edges): gnt = 0, ready = 0, rnd_data = 0x01, grant_cnt = 0 immediately. After release, the reset sequence repeats exactly.
